mips_multicycle_ctrl_v2: RTL

Next-generation multicycle MIPS control FSM. Generated once per core, between instruction register decode and datapath muxes. Adds to the base control set:
- ANDI, ORI, BNE, JAL, JR
- parametrised memory wait-state handshake with bus-timeout counter
- illegal-opcode/timeout trap state with cause code
- fully defined outputs in every state (no X)

---
 rtl/mips_multicycle_ctrl_v2_if.sv | 39 +++
 rtl/mips_multicycle_ctrl_v2.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl_v2_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// Handshake: mem_req stays high until the cycle mem_ready is seen with it; that cycle completes the access.
interface mips_multicycle_ctrl_v2_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       trap_clr;
  logic       mem_req;
  logic       i_or_d;
  logic       ir_write;
  logic       mem_write;
  logic       pc_write;
  logic       branch;
  logic       branch_ne;
  logic       reg_write;
  logic [1:0] reg_dest;
  logic [1:0] mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_src;
  logic       trap;
  logic [1:0] trap_cause;
  logic [4:0] state_dbg;

  modport master (
    input  opcode, funct, mem_ready, trap_clr,
    output mem_req, i_or_d, ir_write, mem_write, pc_write, branch, branch_ne,
           reg_write, reg_dest, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           pc_src, trap, trap_cause, state_dbg
  );

  modport slave (
    output opcode, funct, mem_ready, trap_clr,
    input  mem_req, i_or_d, ir_write, mem_write, pc_write, branch, branch_ne,
           reg_write, reg_dest, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           pc_src, trap, trap_cause, state_dbg
  );
endinterface

// File: rtl/mips_multicycle_ctrl_v2.sv
// Multicycle MIPS control FSM with memory wait states, bus timeout and trap handling.
// state_dbg encodings: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6 ALUWB=7 BEQ=8 BNE=9 IEXEC=10 IWB=11 JUMP=12 JAL=13 JR=14 TRAP=15.
module mips_multicycle_ctrl_v2 #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit EXT_EN        = 1'b1,
  parameter int WAIT_LIMIT    = 15,
  parameter int CNT_W         = 8
) (
  input logic                   clk,
  input logic                   reset_n,
  mips_multicycle_ctrl_v2_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [4:0] {
    S_FETCH  = 5'd0,  S_DECODE = 5'd1,  S_MEMADR = 5'd2,  S_MEMRD = 5'd3,
    S_MEMWB  = 5'd4,  S_MEMWR  = 5'd5,  S_EXEC   = 5'd6,  S_ALUWB = 5'd7,
    S_BEQ    = 5'd8,  S_BNE    = 5'd9,  S_IEXEC  = 5'd10, S_IWB   = 5'd11,
    S_JUMP   = 5'd12, S_JAL    = 5'd13, S_JR     = 5'd14, S_TRAP  = 5'd15
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       i_or_d;
    logic       ir_write;
    logic       mem_write;
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       reg_write;
    logic [1:0] reg_dest;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       trap;
    logic [1:0] trap_cause;
  } ctl_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt, cnt_next;
  logic [1:0]       cause, cause_next;
  ctl_t             c, o;
  logic             mem_done, wait_over, in_mem, illegal, ext;

  assign ext       = EXT_EN;
  assign mem_done  = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
  assign wait_over = (wait_cnt == CNT_W'(WAIT_LIMIT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      cause    <= 2'b00;
    end else begin
      state    <= state_next;
      wait_cnt <= cnt_next;
      cause    <= cause_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = '0;
    cause_next   = cause;
    in_mem       = 1'b0;
    illegal      = 1'b0;
    c            = '0;
    c.trap_cause = cause;
    case (state)
      S_FETCH: begin
        in_mem      = 1'b1;
        c.mem_req   = 1'b1;
        c.alu_src_b = 2'b01;
        c.ir_write  = mem_done;
        c.pc_write  = mem_done;
        state_next  = S_DECODE;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE: begin
            if (bus.funct == FN_JR) begin
              state_next = S_JR;
              illegal    = !ext;
            end else begin
              state_next = S_EXEC;
            end
          end
          OP_BEQ:          state_next = S_BEQ;
          OP_BNE:          begin state_next = S_BNE;   illegal = !ext; end
          OP_ADDI:         state_next = S_IEXEC;
          OP_ANDI, OP_ORI: begin state_next = S_IEXEC; illegal = !ext; end
          OP_J:            state_next = S_JUMP;
          OP_JAL:          begin state_next = S_JAL;   illegal = !ext; end
          default:         illegal = 1'b1;
        endcase
        if (illegal) begin
          state_next = S_TRAP;
          cause_next = 2'b01;
        end
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        state_next  = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        in_mem     = 1'b1;
        c.mem_req  = 1'b1;
        c.i_or_d   = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 2'b01;
        state_next   = S_FETCH;
      end
      S_MEMWR: begin
        in_mem      = 1'b1;
        c.mem_req   = 1'b1;
        c.i_or_d    = 1'b1;
        c.mem_write = 1'b1;
        state_next  = S_FETCH;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 3'b010;
        state_next  = S_ALUWB;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dest  = 2'b01;
        state_next  = S_FETCH;
      end
      S_BEQ, S_BNE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 3'b001;
        c.pc_src    = 2'b01;
        c.branch    = (state == S_BEQ);
        c.branch_ne = (state == S_BNE);
        state_next  = S_FETCH;
      end
      S_IEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        case (bus.opcode)
          OP_ANDI: c.alu_op = 3'b011;
          OP_ORI:  c.alu_op = 3'b100;
          default: c.alu_op = 3'b000;
        endcase
        state_next = S_IWB;
      end
      S_IWB: begin
        c.reg_write = 1'b1;
        state_next  = S_FETCH;
      end
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = 2'b10;
        state_next = S_FETCH;
      end
      // PC already holds PC+4 here, so the link value comes straight from PC.
      S_JAL: begin
        c.reg_write  = 1'b1;
        c.reg_dest   = 2'b10;
        c.mem_to_reg = 2'b10;
        c.pc_write   = 1'b1;
        c.pc_src     = 2'b10;
        state_next   = S_FETCH;
      end
      S_JR: begin
        c.pc_write = 1'b1;
        c.pc_src   = 2'b11;
        state_next = S_FETCH;
      end
      S_TRAP: begin
        c.trap = 1'b1;
        if (bus.trap_clr) begin
          state_next = S_FETCH;
          cause_next = 2'b00;
        end
      end
      default: state_next = S_FETCH;
    endcase
    // A stalled access holds its state until WAIT_LIMIT waits have elapsed.
    if (in_mem && !mem_done) begin
      if (wait_over) begin
        state_next = S_TRAP;
        cause_next = 2'b10;
      end else begin
        state_next = state;
        cnt_next   = wait_cnt + 1'b1;
      end
    end
  end

  // Outputs drop to zero the instant reset_n falls, ahead of any clock edge.
  assign o = reset_n ? c : '0;

  assign bus.mem_req    = o.mem_req;
  assign bus.i_or_d     = o.i_or_d;
  assign bus.ir_write   = o.ir_write;
  assign bus.mem_write  = o.mem_write;
  assign bus.pc_write   = o.pc_write;
  assign bus.branch     = o.branch;
  assign bus.branch_ne  = o.branch_ne;
  assign bus.reg_write  = o.reg_write;
  assign bus.reg_dest   = o.reg_dest;
  assign bus.mem_to_reg = o.mem_to_reg;
  assign bus.alu_src_a  = o.alu_src_a;
  assign bus.alu_src_b  = o.alu_src_b;
  assign bus.alu_op     = o.alu_op;
  assign bus.pc_src     = o.pc_src;
  assign bus.trap       = o.trap;
  assign bus.trap_cause = o.trap_cause;
  assign bus.state_dbg  = state;

endmodule
